// File: rtl/ifft_stage4_sdf_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifft_stage4_sdf_ctrl_if
// Bundles the sample handshake and the control/twiddle outputs of one
// single-path delay-feedback IFFT stage controller.
//
// Handshake: a sample moves into the stage on a rising clk edge where
// in_valid and in_ready are both 1. in_ready never depends on in_valid.
// tw_valid/out_valid are single-cycle qualifiers with no back-pressure.
//
// Signals:
//   in_valid  - a sample is presented this cycle (source -> stage)
//   in_ready  - stage can take a sample this cycle
//   dl_en     - shift delay line / run butterfly this cycle (combinational)
//   bf_sel    - 0 fill/pass-through, 1 butterfly compute (combinational)
//   tw_addr   - twiddle ROM address = output-sample index in the frame
//   tw_valid  - tw_addr qualifies a sample entering the multiplier
//   out_valid - multiplier output valid
//   out_last  - multiplier output is the last sample of the frame
//   busy      - controller is not idle
// Modports: master = sample source / consumer side, slave = controller.
// ---------------------------------------------------------------------------
interface ifft_stage4_sdf_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       dl_en;
    logic       bf_sel;
    logic [5:0] tw_addr;
    logic       tw_valid;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    modport master (
        output in_valid,
        input  in_ready, dl_en, bf_sel, tw_addr, tw_valid,
        input  out_valid, out_last, busy
    );

    modport slave (
        input  in_valid,
        output in_ready, dl_en, bf_sel, tw_addr, tw_valid,
        output out_valid, out_last, busy
    );
endinterface

// File: rtl/ifft_stage4_sdf_ctrl.sv
// ---------------------------------------------------------------------------
// ifft_stage4_sdf_ctrl
// Control path of one SDF (single-path delay-feedback) IFFT stage.
// Counts input samples within a frame, alternates the butterfly between
// fill (DELAY samples) and compute (DELAY samples), flushes the delay line
// after the final frame of a burst, and generates twiddle addresses plus
// the multiplier-output qualifiers.
//
// Parameters:
//   NFFT    - points per frame (power of two)
//   DELAY   - delay-line length of this stage (power of two, < NFFT)
//   LATENCY - complex-multiplier pipeline depth in cycles (>= 1)
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - handshake / control bundle (slave side)
//   dbg_state - current FSM state (0 IDLE, 1 RUN, 2 FLUSH)
//   dbg_in_cnt- current input sample counter
// ---------------------------------------------------------------------------
module ifft_stage4_sdf_ctrl #(
    parameter int NFFT    = 64,
    parameter int DELAY   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ifft_stage4_sdf_ctrl_if.slave    bus,
    output logic [1:0]               dbg_state,
    output logic [$clog2(NFFT)-1:0]  dbg_in_cnt
);
    localparam int LOG_N = $clog2(NFFT);
    localparam int LOG_D = $clog2(DELAY);
    localparam logic [LOG_N-1:0] CNT_DLAST = LOG_N'(DELAY - 1);
    localparam logic [5:0]       ADDR_LAST = 6'(NFFT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LOG_N-1:0]   in_cnt;
    logic [5:0]         out_cnt;
    logic               primed;
    logic [5:0]         tw_addr_q;
    logic               tw_valid_q;
    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] last_pipe;

    logic ready;
    logic accept;
    logic flushing;
    logic flush_done;
    logic shift_en;
    logic emit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // In RUN, in_cnt can only be 0 after wrapping from NFFT-1, so a zero
    // count without an accept marks the end of a burst of frames.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if ((in_cnt == '0) && !accept) state_nxt = FLUSH;
            FLUSH:   if (in_cnt == CNT_DLAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rst is folded in so the handshake reads sane values while reset is
    // held, independent of whatever the registers held before it.
    always_comb begin
        ready      = rst || (state != FLUSH);
        accept     = bus.in_valid && ready && !rst;
        flushing   = !rst && (state == FLUSH);
        flush_done = flushing && (in_cnt == CNT_DLAST);
        shift_en   = accept || flushing;
        emit       = shift_en && primed;
    end

    // ---------------- counters and twiddle address ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            primed     <= 1'b0;
            out_cnt    <= '0;
            tw_addr_q  <= '0;
            tw_valid_q <= 1'b0;
        end else begin
            // Leaving FLUSH re-aligns the input counter for the next frame.
            if (flush_done) begin
                in_cnt <= '0;
            end else if (shift_en) begin
                in_cnt <= in_cnt + 1'b1;
            end

            // Once the first DELAY samples are in the line every further
            // shift produces an output sample.
            if (flush_done) begin
                primed <= 1'b0;
            end else if (shift_en && (in_cnt == CNT_DLAST)) begin
                primed <= 1'b1;
            end

            tw_valid_q <= emit;
            if (emit) begin
                tw_addr_q <= out_cnt;
                out_cnt   <= out_cnt + 1'b1;
            end
        end
    end

    // ---------------- multiplier latency match ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= tw_valid_q;
            last_pipe[0] <= tw_valid_q && (tw_addr_q == ADDR_LAST);
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    // ---------------- bundle drive ----------------
    always_comb begin
        bus.in_ready  = ready;
        bus.dl_en     = shift_en;
        bus.bf_sel    = !rst && (state != FLUSH) && in_cnt[LOG_D];
        bus.tw_addr   = tw_addr_q;
        bus.tw_valid  = tw_valid_q;
        bus.out_valid = vld_pipe[LATENCY-1];
        bus.out_last  = last_pipe[LATENCY-1];
        bus.busy      = (state != IDLE);
        dbg_state     = state;
        dbg_in_cnt    = in_cnt;
    end
endmodule
